// File: rtl/cam_pkg.sv
// Shared types and sizing for the CAM command sequencer and its valid-slot tracker.
package cam_pkg;

  localparam int NB_MEM    = 12;
  localparam int SIZE_ADDR = 4;
  localparam int DATA_W    = 8;
  localparam int IDX_W     = 5;
  localparam int CNT_W     = 4;
  localparam int IDX_SPAN  = 1 << IDX_W;

  typedef enum logic [1:0] {
    OP_LOOKUP     = 2'd0,
    OP_WRITE      = 2'd1,
    OP_INVALIDATE = 2'd2,
    OP_RSVD       = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    ST_OK   = 2'd0,
    ST_MISS = 2'd1,
    ST_DUP  = 2'd2,
    ST_ERR  = 2'd3
  } status_e;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_ISSUE_LK = 3'd1,
    S_CHECK    = 3'd2,
    S_ISSUE_WR = 3'd3,
    S_RESP     = 3'd4
  } state_e;

endpackage

// File: rtl/cam_valid_tracker.sv
// Per-slot valid bitmap plus a saturating occupancy counter; masks stale store entries.
module cam_valid_tracker
  import cam_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             set_i,
  input  logic             clr_i,
  input  logic [IDX_W-1:0] idx_i,
  input  logic [IDX_W-1:0] qry_idx_i,
  output logic             qry_bit_o,
  output logic [CNT_W-1:0] occupancy_o
);

  logic [NB_MEM-1:0]   bitmap_q;
  logic [CNT_W-1:0]    occ_q;
  logic [IDX_SPAN-1:0] bitmap_ext;
  logic                in_range;
  logic                idx_bit;

  // Zero-padding to the full index span keeps out-of-range queries reading as invalid.
  assign bitmap_ext  = {{(IDX_SPAN - NB_MEM){1'b0}}, bitmap_q};
  assign qry_bit_o   = bitmap_ext[qry_idx_i];
  assign idx_bit     = bitmap_ext[idx_i];
  assign in_range    = idx_i < IDX_W'(NB_MEM);
  assign occupancy_o = occ_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      bitmap_q <= '0;
      occ_q    <= '0;
    end else if (in_range) begin
      if (set_i && !idx_bit) begin
        bitmap_q[idx_i[SIZE_ADDR-1:0]] <= 1'b1;
        if (occ_q < CNT_W'(NB_MEM)) occ_q <= occ_q + CNT_W'(1);
      end else if (clr_i && idx_bit) begin
        bitmap_q[idx_i[SIZE_ADDR-1:0]] <= 1'b0;
        if (occ_q != '0) occ_q <= occ_q - CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/cam_seq.sv
// Command sequencer in front of the 12-entry CAM store: lookup-before-write, one command in flight.
module cam_seq
  import cam_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [IDX_W-1:0]  cmd_addr,
  input  logic [DATA_W-1:0] cmd_data,
  output logic              cam_write,
  output logic              cam_enable,
  output logic [IDX_W-1:0]  cam_addr,
  output logic [DATA_W-1:0] cam_data,
  input  logic [IDX_W-1:0]  cam_out,
  input  logic              cam_found,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [1:0]        rsp_status,
  output logic [IDX_W-1:0]  rsp_idx,
  output logic [CNT_W-1:0]  occupancy
);

  state_e              state_q;
  op_e                 op_q;
  logic [IDX_W-1:0]    addr_q;
  logic [DATA_W-1:0]   key_q;
  logic                cmd_ready_q;
  logic                cam_write_q;
  logic                cam_enable_q;
  logic [IDX_W-1:0]    cam_addr_q;
  logic [DATA_W-1:0]   cam_data_q;
  logic                rsp_valid_q;
  status_e             rsp_status_q;
  logic [IDX_W-1:0]    rsp_idx_q;

  logic                accept;
  logic                addr_bad;
  logic                trk_set;
  logic                trk_clr;
  logic [IDX_W-1:0]    trk_idx;
  logic                slot_valid;
  logic                hit;

  assign accept   = (state_q == S_IDLE) && cmd_valid && cmd_ready_q;
  assign addr_bad = cmd_addr >= IDX_W'(NB_MEM);

  // Invalidate clears at the accept edge; a performed write sets on leaving ISSUE_WR.
  assign trk_clr  = accept && (op_e'(cmd_op) == OP_INVALIDATE) && !addr_bad;
  assign trk_set  = (state_q == S_ISSUE_WR);
  assign trk_idx  = (state_q == S_ISSUE_WR) ? addr_q : cmd_addr;
  assign hit      = cam_found && slot_valid;

  cam_valid_tracker u_tracker (
    .clk         (clk),
    .rst         (rst),
    .set_i       (trk_set),
    .clr_i       (trk_clr),
    .idx_i       (trk_idx),
    .qry_idx_i   (cam_out),
    .qry_bit_o   (slot_valid),
    .occupancy_o (occupancy)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      op_q         <= OP_LOOKUP;
      addr_q       <= '0;
      key_q        <= '0;
      cmd_ready_q  <= 1'b0;
      cam_write_q  <= 1'b0;
      cam_enable_q <= 1'b0;
      cam_addr_q   <= '0;
      cam_data_q   <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_status_q <= ST_OK;
      rsp_idx_q    <= '0;
    end else begin
      cam_write_q  <= 1'b0;
      cam_enable_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          cmd_ready_q <= 1'b1;
          if (accept) begin
            cmd_ready_q <= 1'b0;
            op_q        <= op_e'(cmd_op);
            addr_q      <= cmd_addr;
            key_q       <= cmd_data;
            if (op_e'(cmd_op) == OP_RSVD ||
                ((op_e'(cmd_op) == OP_WRITE || op_e'(cmd_op) == OP_INVALIDATE) && addr_bad)) begin
              state_q      <= S_RESP;
              rsp_valid_q  <= 1'b1;
              rsp_status_q <= ST_ERR;
              rsp_idx_q    <= '0;
            end else if (op_e'(cmd_op) == OP_INVALIDATE) begin
              state_q      <= S_RESP;
              rsp_valid_q  <= 1'b1;
              rsp_status_q <= ST_OK;
              rsp_idx_q    <= cmd_addr;
            end else begin
              state_q      <= S_ISSUE_LK;
              cam_enable_q <= 1'b1;
              cam_data_q   <= cmd_data;
            end
          end
        end
        S_ISSUE_LK: state_q <= S_CHECK;
        S_CHECK: begin
          if (op_q == OP_LOOKUP) begin
            state_q      <= S_RESP;
            rsp_valid_q  <= 1'b1;
            rsp_status_q <= hit ? ST_OK : ST_MISS;
            rsp_idx_q    <= hit ? cam_out : '0;
          end else if (hit) begin
            // Key already stored: never issue a second copy of it.
            state_q      <= S_RESP;
            rsp_valid_q  <= 1'b1;
            rsp_status_q <= (cam_out == addr_q) ? ST_OK : ST_DUP;
            rsp_idx_q    <= cam_out;
          end else begin
            state_q     <= S_ISSUE_WR;
            cam_write_q <= 1'b1;
            cam_addr_q  <= addr_q;
            cam_data_q  <= key_q;
          end
        end
        S_ISSUE_WR: begin
          state_q      <= S_RESP;
          rsp_valid_q  <= 1'b1;
          rsp_status_q <= ST_OK;
          rsp_idx_q    <= addr_q;
        end
        S_RESP: begin
          if (rsp_ready) begin
            state_q     <= S_IDLE;
            rsp_valid_q <= 1'b0;
            cmd_ready_q <= 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign cmd_ready  = cmd_ready_q;
  assign cam_write  = cam_write_q;
  assign cam_enable = cam_enable_q;
  assign cam_addr   = cam_addr_q;
  assign cam_data   = cam_data_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_status = rsp_status_q;
  assign rsp_idx    = rsp_idx_q;

endmodule

// File: tb/tb_cam_seq.sv
// Directed bench for cam_seq with a behavioural 12-entry CAM store (highest matching slot wins).
module tb_cam_seq;
  import cam_pkg::*;

  logic              clk = 1'b0;
  logic              rst;
  logic              cmd_valid;
  logic              cmd_ready;
  logic [1:0]        cmd_op;
  logic [IDX_W-1:0]  cmd_addr;
  logic [DATA_W-1:0] cmd_data;
  logic              cam_write;
  logic              cam_enable;
  logic [IDX_W-1:0]  cam_addr;
  logic [DATA_W-1:0] cam_data;
  logic [IDX_W-1:0]  cam_out;
  logic              cam_found;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [1:0]        rsp_status;
  logic [IDX_W-1:0]  rsp_idx;
  logic [CNT_W-1:0]  occupancy;

  int checkCount = 0;
  int passCount  = 0;

  logic [DATA_W-1:0] storeKey [NB_MEM];
  logic [NB_MEM-1:0] storeWritten = '0;
  logic [IDX_W-1:0]  camOutQ = '0;
  logic              camFoundQ = 1'b0;
  logic              searchFound;
  logic [IDX_W-1:0]  searchIdx;
  int                enCount = 0;
  int                wrCount = 0;
  logic [IDX_W-1:0]  lastWrAddr = '0;
  logic [DATA_W-1:0] lastWrData = '0;

  logic [1:0]        rspStatus;
  logic [IDX_W-1:0]  rspIdx;
  int                latency;
  int                enPulses;
  int                wrPulses;
  logic              holdStable;

  assign cam_out   = camOutQ;
  assign cam_found = camFoundQ;

  cam_seq dut (
    .clk        (clk),
    .rst        (rst),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_op     (cmd_op),
    .cmd_addr   (cmd_addr),
    .cmd_data   (cmd_data),
    .cam_write  (cam_write),
    .cam_enable (cam_enable),
    .cam_addr   (cam_addr),
    .cam_data   (cam_data),
    .cam_out    (cam_out),
    .cam_found  (cam_found),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_status (rsp_status),
    .rsp_idx    (rsp_idx),
    .occupancy  (occupancy)
  );

  always #5 clk = ~clk;

  // Store model: not cleared by rst, reports the highest written slot holding the key.
  always @(posedge clk) begin
    if (cam_write && cam_addr < IDX_W'(NB_MEM)) begin
      storeKey[cam_addr[SIZE_ADDR-1:0]]     <= cam_data;
      storeWritten[cam_addr[SIZE_ADDR-1:0]] <= 1'b1;
    end
    if (cam_enable) begin
      searchFound = 1'b0;
      searchIdx   = '0;
      for (int i = 0; i < NB_MEM; i++) begin
        if (storeWritten[i] && storeKey[i] == cam_data) begin
          searchFound = 1'b1;
          searchIdx   = IDX_W'(i);
        end
      end
      camFoundQ <= searchFound;
      camOutQ   <= searchIdx;
    end
    if (cam_enable) enCount <= enCount + 1;
    if (cam_write) begin
      wrCount    <= wrCount + 1;
      lastWrAddr <= cam_addr;
      lastWrData <= cam_data;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    assert (observed === expected) passCount++;
    else $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
  endtask

  // Runs one command through the handshake; latency counts edges from accept edge A.
  task automatic applyStimulus(input logic [1:0] op, input logic [IDX_W-1:0] addr,
                               input logic [DATA_W-1:0] data, input int holdCycles);
    int guard;
    int enStart;
    int wrStart;
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_addr  = addr;
    cmd_data  = data;
    guard = 0;
    while (!cmd_ready && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    checkOutput("cmd_ready before accept", 32'(cmd_ready), 32'd1);
    enStart = enCount;
    wrStart = wrCount;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    latency = 1;
    while (!rsp_valid && latency < 50) begin
      @(posedge clk); #1;
      latency++;
    end
    rspStatus = rsp_status;
    rspIdx    = rsp_idx;
    enPulses  = enCount - enStart;
    wrPulses  = wrCount - wrStart;
    if (holdCycles > 0) begin
      holdStable = 1'b1;
      for (int k = 0; k < holdCycles; k++) begin
        @(posedge clk); #1;
        if (!rsp_valid || rsp_status !== rspStatus || rsp_idx !== rspIdx || cmd_ready !== 1'b0)
          holdStable = 1'b0;
      end
      checkOutput("rsp held while stalled", 32'(holdStable), 32'd1);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
  endtask

  initial begin
    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_op    = '0;
    cmd_addr  = '0;
    cmd_data  = '0;
    rsp_ready = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    checkOutput("reset cmd_ready", 32'(cmd_ready), 32'd0);
    checkOutput("reset rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("reset strobes", 32'({cam_write, cam_enable}), 32'd0);
    checkOutput("reset occupancy", 32'(occupancy), 32'd0);
    rst = 1'b0;

    applyStimulus(2'd0, 5'd0, 8'h5A, 0);
    checkOutput("lookup miss status", 32'(rspStatus), 32'd1);
    checkOutput("lookup miss idx", 32'(rspIdx), 32'd0);
    checkOutput("lookup latency", 32'(latency), 32'd3);
    checkOutput("lookup enable pulses", 32'(enPulses), 32'd1);
    checkOutput("lookup write pulses", 32'(wrPulses), 32'd0);

    applyStimulus(2'd1, 5'd3, 8'hA5, 0);
    checkOutput("write status", 32'(rspStatus), 32'd0);
    checkOutput("write idx", 32'(rspIdx), 32'd3);
    checkOutput("write latency", 32'(latency), 32'd4);
    checkOutput("write pulses", 32'(wrPulses), 32'd1);
    checkOutput("write strobe addr", 32'(lastWrAddr), 32'd3);
    checkOutput("write strobe data", 32'(lastWrData), 32'hA5);

    applyStimulus(2'd0, 5'd0, 8'hA5, 0);
    checkOutput("lookup hit", 32'({rspStatus, rspIdx}), 32'({2'd0, 5'd3}));
    checkOutput("occupancy after write", 32'(occupancy), 32'd1);

    applyStimulus(2'd1, 5'd7, 8'hA5, 0);
    checkOutput("dup write", 32'({rspStatus, rspIdx}), 32'({2'd2, 5'd3}));
    checkOutput("dup write pulses", 32'(wrPulses), 32'd0);
    checkOutput("dup latency", 32'(latency), 32'd3);
    checkOutput("occupancy after dup", 32'(occupancy), 32'd1);

    applyStimulus(2'd1, 5'd3, 8'hA5, 0);
    checkOutput("same-slot rewrite", 32'({rspStatus, rspIdx}), 32'({2'd0, 5'd3}));
    checkOutput("same-slot write pulses", 32'(wrPulses), 32'd0);

    applyStimulus(2'd1, 5'd12, 8'h77, 0);
    checkOutput("bad addr write", 32'({rspStatus, rspIdx}), 32'({2'd3, 5'd0}));
    checkOutput("err latency", 32'(latency), 32'd1);
    checkOutput("err strobes", 32'(enPulses + wrPulses), 32'd0);

    applyStimulus(2'd3, 5'd0, 8'h00, 0);
    checkOutput("reserved op", 32'({rspStatus, rspIdx}), 32'({2'd3, 5'd0}));

    applyStimulus(2'd2, 5'd3, 8'h00, 0);
    checkOutput("invalidate", 32'({rspStatus, rspIdx}), 32'({2'd0, 5'd3}));
    checkOutput("invalidate latency", 32'(latency), 32'd1);
    checkOutput("occupancy after invalidate", 32'(occupancy), 32'd0);

    applyStimulus(2'd0, 5'd0, 8'hA5, 0);
    checkOutput("stale hit masked", 32'({rspStatus, rspIdx}), 32'({2'd1, 5'd0}));

    applyStimulus(2'd0, 5'd0, 8'h11, 5);
    checkOutput("stalled lookup", 32'(rspStatus), 32'd1);

    // Reset lands while the write strobe is on the wire.
    cmd_valid = 1'b1;
    cmd_op    = 2'd1;
    cmd_addr  = 5'd5;
    cmd_data  = 8'h33;
    checkOutput("ready before mid-write reset", 32'(cmd_ready), 32'd1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    checkOutput("write strobe before reset", 32'(cam_write), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    checkOutput("mid reset strobes", 32'({cam_write, cam_enable}), 32'd0);
    checkOutput("mid reset cam bus", 32'({cam_addr, cam_data}), 32'd0);
    checkOutput("mid reset rsp", 32'({rsp_valid, rsp_status, rsp_idx}), 32'd0);
    checkOutput("mid reset ready", 32'(cmd_ready), 32'd0);
    checkOutput("mid reset occupancy", 32'(occupancy), 32'd0);
    rst = 1'b0;

    applyStimulus(2'd0, 5'd0, 8'h33, 0);
    checkOutput("bitmap cleared by reset", 32'({rspStatus, rspIdx}), 32'({2'd1, 5'd0}));

    for (int i = 0; i < NB_MEM; i++) begin
      applyStimulus(2'd1, IDX_W'(i), DATA_W'(8'h80 + i), 0);
      checkOutput("fill write", 32'({rspStatus, rspIdx}), 32'({2'd0, IDX_W'(i)}));
    end
    checkOutput("occupancy full", 32'(occupancy), 32'd12);

    applyStimulus(2'd1, 5'd0, 8'hC0, 0);
    checkOutput("rewrite slot 0", 32'({rspStatus, rspIdx}), 32'({2'd0, 5'd0}));
    checkOutput("rewrite pulses", 32'(wrPulses), 32'd1);
    checkOutput("occupancy saturated", 32'(occupancy), 32'd12);

    applyStimulus(2'd0, 5'd0, 8'h8B, 0);
    checkOutput("lookup top slot", 32'({rspStatus, rspIdx}), 32'({2'd0, 5'd11}));

    applyStimulus(2'd2, 5'd4, 8'h00, 0);
    checkOutput("occupancy after invalidate 4", 32'(occupancy), 32'd11);
    applyStimulus(2'd2, 5'd4, 8'h00, 0);
    checkOutput("invalidate empty slot", 32'({rspStatus, rspIdx}), 32'({2'd0, 5'd4}));
    checkOutput("occupancy unchanged", 32'(occupancy), 32'd11);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
